btb_assoc: RTL and testbench

BTB_ASSOC -- requirements
Module: btb_assoc

---
 rtl/btb_assoc.sv | 189 ++++++++++++++++++
 tb/tb_btb_assoc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc.sv
// ---------------------------------------------------------------------------
// btb_assoc -- set-associative branch target buffer
//
// Purpose:
//   Predicts branch targets with a WAYS-way, SETS-set table. A lookup
//   registers its hit, target and taken prediction one cycle later. A resolved
//   branch either refreshes its entry or, if it was taken, allocates one.
//   Victim selection uses the lowest invalid way first, then a round-robin
//   pointer kept for each set.
//
// Parameters:
//   WAYS      associativity (power of two, 1..8)
//   SETS      number of sets (power of two, 2..64)
//   PC_WIDTH  width of PCs and targets
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   lookup_valid   in   lookup request this cycle
//   lookup_pc      in   PC to look up
//   hit            out  registered: previous lookup matched
//   target_pc      out  registered: target of the matching entry (0 on miss)
//   predict_taken  out  registered: taken prediction for the previous lookup
//   update_valid   in   resolved-branch update this cycle
//   update_pc      in   PC of the resolved branch
//   update_target  in   resolved target
//   update_taken   in   resolved direction
//   flush          in   invalidate all entries
//
// Configuration macro:
//   BTB_COUNTER_EN  adds a 2-bit saturating counter per entry that drives
//                   predict_taken. Without it, predict_taken follows hit, and a
//                   not-taken update that hits invalidates the entry.
// ---------------------------------------------------------------------------
module btb_assoc #(
  parameter int WAYS     = 2,
  parameter int SETS     = 8,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                lookup_valid,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                hit,
  output logic [PC_WIDTH-1:0] target_pc,
  output logic                predict_taken,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic [PC_WIDTH-1:0] update_target,
  input  logic                update_taken,
  input  logic                flush
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Control state: reset and flushed
  logic [WAYS-1:0]     r_valid [SETS];
  logic [PTR_W-1:0]    r_ptr   [SETS];
  // Payload storage: never reset, only meaningful under r_valid
  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
  logic [PC_WIDTH-1:0] r_tgt   [SETS][WAYS];
`ifdef BTB_COUNTER_EN
  logic [1:0]          r_ctr   [SETS][WAYS];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction
`endif

  // PC bits [1:0] do not take part in indexing or tagging
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = lookup_pc[PC_WIDTH-1:IDX_W+2];
  assign w_up_idx = update_pc[IDX_W+1:2];
  assign w_up_tag = update_pc[PC_WIDTH-1:IDX_W+2];

  // Lookup compare; scanning downward leaves the lowest matching way selected
  logic             w_lk_hit;
  logic [PTR_W-1:0] w_lk_way;
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
        w_lk_hit = 1'b1;
        w_lk_way = PTR_W'(w);
      end
    end
  end

  // Update compare, plus the lowest invalid way as the preferred victim
  logic             w_up_hit, w_up_has_inv;
  logic [PTR_W-1:0] w_up_way, w_inv_way, w_alloc_way, w_ptr_next;
  always_comb begin
    w_up_hit     = 1'b0;
    w_up_way     = '0;
    w_up_has_inv = 1'b0;
    w_inv_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
        w_up_hit = 1'b1;
        w_up_way = PTR_W'(w);
      end
      if (!r_valid[w_up_idx][w]) begin
        w_up_has_inv = 1'b1;
        w_inv_way    = PTR_W'(w);
      end
    end
  end

  assign w_alloc_way = w_up_has_inv ? w_inv_way : r_ptr[w_up_idx];
  assign w_ptr_next  = (r_ptr[w_up_idx] == PTR_W'(WAYS - 1)) ? '0
                     : r_ptr[w_up_idx] + PTR_W'(1);

  logic w_wr_en;
  assign w_wr_en = update_valid && !flush;

  // Stage p1: registered lookup result (reads pre-update, pre-flush contents)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit           <= 1'b0;
      target_pc     <= '0;
      predict_taken <= 1'b0;
    end else begin
      hit       <= lookup_valid && w_lk_hit;
      target_pc <= (lookup_valid && w_lk_hit) ? r_tgt[w_lk_idx][w_lk_way] : '0;
`ifdef BTB_COUNTER_EN
      predict_taken <= lookup_valid && w_lk_hit && r_ctr[w_lk_idx][w_lk_way][1];
`else
      predict_taken <= lookup_valid && w_lk_hit;
`endif
    end
  end

  // Valid bits and victim pointers; flush wins over a same-cycle update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else if (update_valid) begin
      if (w_up_hit) begin
`ifndef BTB_COUNTER_EN
        if (!update_taken) r_valid[w_up_idx][w_up_way] <= 1'b0;
`endif
      end else if (update_taken) begin
        r_valid[w_up_idx][w_alloc_way] <= 1'b1;
        // The pointer only advances when it actually chose the victim
        if (!w_up_has_inv) r_ptr[w_up_idx] <= w_ptr_next;
      end
    end
  end

  // Payload writes
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (w_up_hit) begin
        r_tgt[w_up_idx][w_up_way] <= update_target;
`ifdef BTB_COUNTER_EN
        r_ctr[w_up_idx][w_up_way] <= update_taken ? sat_inc(r_ctr[w_up_idx][w_up_way])
                                                  : sat_dec(r_ctr[w_up_idx][w_up_way]);
`endif
      end else if (update_taken) begin
        r_tag[w_up_idx][w_alloc_way] <= w_up_tag;
        r_tgt[w_up_idx][w_alloc_way] <= update_target;
`ifdef BTB_COUNTER_EN
        r_ctr[w_up_idx][w_alloc_way] <= 2'b10;
`endif
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// ---------------------------------------------------------------------------
// tb_btb_assoc -- directed self-checking bench for btb_assoc
// (WAYS=2, SETS=8, PC_WIDTH=32). With 0x100-style PCs, index = pc[4:2] and
// tag = pc[31:5]: 0x100/0x120/0x140/0x160/0x180/0x1A0 all map to set 0,
// and 0x204 maps to set 1.
// ---------------------------------------------------------------------------
module tb_btb_assoc;

  logic        clk;
  logic        reset_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        hit;
  logic [31:0] target_pc;
  logic        predict_taken;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        flush;

  int n_checks = 0;
  int n_pass   = 0;

  btb_assoc #(.WAYS(2), .SETS(8), .PC_WIDTH(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .hit           (hit),
    .target_pc     (target_pc),
    .predict_taken (predict_taken),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_target = tgt;
    update_taken  = taken;
    tick();
    update_valid  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_lookup(input string tag, input logic [31:0] pc,
                           input logic eh, input logic [31:0] et, input logic ep);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
    check({tag, ".hit"}, {31'd0, hit}, {31'd0, eh});
    check({tag, ".tgt"}, target_pc, et);
    check({tag, ".pt"},  {31'd0, predict_taken}, {31'd0, ep});
  endtask

  initial begin
    reset_n       = 1'b0;
    lookup_valid  = 1'b0;
    lookup_pc     = '0;
    update_valid  = 1'b0;
    update_pc     = '0;
    update_target = '0;
    update_taken  = 1'b0;
    flush         = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst.hit", {31'd0, hit}, 32'd0);
    check("rst.tgt", target_pc, 32'd0);
    check("rst.pt",  {31'd0, predict_taken}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Cold lookup misses
    do_lookup("cold", 32'h100, 1'b0, 32'h0, 1'b0);

    // Allocate and hit
    do_update(32'h100, 32'h400, 1'b1);
    do_lookup("alloc", 32'h100, 1'b1, 32'h400, 1'b1);

    // No lookup request -> outputs return to zero
    tick();
    check("idle.hit", {31'd0, hit}, 32'd0);
    check("idle.tgt", target_pc, 32'd0);

    // Low PC bits are ignored
    do_lookup("lsb", 32'h103, 1'b1, 32'h400, 1'b1);

    // Update hit overwrites target
    do_update(32'h100, 32'h440, 1'b1);
    do_lookup("retgt", 32'h100, 1'b1, 32'h440, 1'b1);

    // Three taken branches into a 2-way set: 0x140 evicts way0 (0x100), ptr->1
    do_flush();
    do_update(32'h100, 32'h400, 1'b1);
    do_update(32'h120, 32'h500, 1'b1);
    do_update(32'h140, 32'h600, 1'b1);
    do_lookup("evict.100", 32'h100, 1'b0, 32'h0,   1'b0);
    do_lookup("evict.120", 32'h120, 1'b1, 32'h500, 1'b1);
    do_lookup("evict.140", 32'h140, 1'b1, 32'h600, 1'b1);
    // Round-robin: next victim is way1 (0x120)
    do_update(32'h160, 32'h680, 1'b1);
    do_lookup("rr.120", 32'h120, 1'b0, 32'h0,   1'b0);
    do_lookup("rr.140", 32'h140, 1'b1, 32'h600, 1'b1);
    do_lookup("rr.160", 32'h160, 1'b1, 32'h680, 1'b1);

    // Not-taken update miss does not allocate
    do_flush();
    do_update(32'h1A0, 32'h800, 1'b0);
    do_lookup("ntmiss", 32'h1A0, 1'b0, 32'h0, 1'b0);

    // Same-cycle lookup and update of the same PC: read-before-write
    do_flush();
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h180;
    update_valid  = 1'b1;
    update_pc     = 32'h180;
    update_target = 32'h700;
    update_taken  = 1'b1;
    tick();
    lookup_valid  = 1'b0;
    update_valid  = 1'b0;
    check("rbw.hit", {31'd0, hit}, 32'd0);
    check("rbw.tgt", target_pc, 32'd0);
    do_lookup("rbw.after", 32'h180, 1'b1, 32'h700, 1'b1);

    // Two not-taken updates after allocation
    do_flush();
    do_update(32'h100, 32'h400, 1'b1);
    do_update(32'h100, 32'h400, 1'b0);
    do_update(32'h100, 32'h400, 1'b0);
`ifdef BTB_COUNTER_EN
    do_lookup("nt2", 32'h100, 1'b1, 32'h400, 1'b0);
`else
    do_lookup("nt2", 32'h100, 1'b0, 32'h0, 1'b0);
`endif

    // Flush: same-cycle lookup sees old contents, same-cycle update is dropped
    do_update(32'h100, 32'h400, 1'b1);
    do_update(32'h204, 32'h900, 1'b1);
    do_lookup("pre.204", 32'h204, 1'b1, 32'h900, 1'b1);
    flush         = 1'b1;
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h100;
    update_valid  = 1'b1;
    update_pc     = 32'h300;
    update_target = 32'hA00;
    update_taken  = 1'b1;
    tick();
    flush         = 1'b0;
    lookup_valid  = 1'b0;
    update_valid  = 1'b0;
    check("fl.same.hit", {31'd0, hit}, 32'd1);
    check("fl.same.tgt", target_pc, 32'h400);
    do_lookup("fl.100", 32'h100, 1'b0, 32'h0, 1'b0);
    do_lookup("fl.204", 32'h204, 1'b0, 32'h0, 1'b0);
    do_lookup("fl.300", 32'h300, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset in the middle of a lookup
    do_update(32'h100, 32'h400, 1'b1);
    do_lookup("prerst", 32'h100, 1'b1, 32'h400, 1'b1);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h100;
    update_valid = 1'b1;
    update_pc    = 32'h204;
    update_target = 32'h900;
    update_taken = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.hit", {31'd0, hit}, 32'd0);
    check("arst.tgt", target_pc, 32'd0);
    check("arst.pt",  {31'd0, predict_taken}, 32'd0);
    tick();
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    do_lookup("post.100", 32'h100, 1'b0, 32'h0, 1'b0);
    do_lookup("post.204", 32'h204, 1'b0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
